// File: rtl/trigger_scheduler_if.sv
// Purpose: bundles the requester handshake and the shared-unit handshake of
// trigger_scheduler into one interface.
// Signals:
//   req          requester -> scheduler, level request per requester
//   grant        scheduler -> requester, one-hot requester being served
//   ack / err    scheduler -> requester, one-cycle completion / timeout
//   busy         scheduler -> requester, high whenever a job or gap is in progress
//   trig_out     scheduler -> unit, one-cycle trigger pulse per job
//   unit_active  unit -> scheduler, unit is running
//   unit_done    unit -> scheduler, unit finished
// Modports: master = environment side (requesters + unit), slave = scheduler.
interface trigger_scheduler_if #(
   parameter int unsigned N_REQ = 4
);
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] grant;
   logic [N_REQ-1:0] ack;
   logic [N_REQ-1:0] err;
   logic             busy;
   logic             trig_out;
   logic             unit_active;
   logic             unit_done;

   modport master (
      output req, unit_active, unit_done,
      input  grant, ack, err, busy, trig_out
   );

   modport slave (
      input  req, unit_active, unit_done,
      output grant, ack, err, busy, trig_out
   );
endinterface

// File: rtl/trigger_scheduler.sv
// Purpose: round-robin scheduler sharing one timed-activity unit among N_REQ
// requesters. Fires a one-cycle trigger, waits for the unit's active/done
// response with a timeout, returns ack or err to the granted requester and
// then holds a quiet gap before the next arbitration.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      trigger_scheduler_if.slave (req, unit_active, unit_done in;
//            trig_out, grant, ack, err, busy out, all registered)
module trigger_scheduler #(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned TIMEOUT    = 15,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   trigger_scheduler_if.slave  bus
);

   localparam int unsigned PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned TMAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
   localparam int unsigned TW   = $clog2(TMAX + 1);

   localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FIRE,
      S_WAIT_ACT,
      S_WAIT_DONE,
      S_ACK,
      S_ERR,
      S_GAP
   } state_t;

   state_t        state;
   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] gidx;
   logic [TW-1:0] timer;

   logic          pick_vld_c;
   logic [PW-1:0] pick_idx_c;
   logic [PW-1:0] scan_idx_c;
   logic [PW-1:0] next_ptr_c;
   logic [N_REQ-1:0] pick_oh_c;

   // Round-robin pick: scan from the highest offset down so the lowest offset
   // from rr_ptr with a pending request wins.
   always_comb begin
      pick_vld_c = 1'b0;
      pick_idx_c = '0;
      scan_idx_c = '0;
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
         scan_idx_c = PW'((int'(rr_ptr) + i) % int'(N_REQ));
         if (bus.req[scan_idx_c]) begin
            pick_vld_c = 1'b1;
            pick_idx_c = scan_idx_c;
         end
      end
   end

   // One-hot of the pick and explicit mod-N_REQ pointer advance.
   always_comb begin
      pick_oh_c             = '0;
      pick_oh_c[pick_idx_c] = 1'b1;
      next_ptr_c            = (gidx == LAST_IDX) ? '0 : gidx + PW'(1);
   end

   // Job sequencer; outputs are registered alongside the state they belong to.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         rr_ptr       <= '0;
         gidx         <= '0;
         timer        <= '0;
         bus.trig_out <= 1'b0;
         bus.grant    <= '0;
         bus.ack      <= '0;
         bus.err      <= '0;
         bus.busy     <= 1'b0;
      end else begin
         bus.trig_out <= 1'b0;
         bus.ack      <= '0;
         bus.err      <= '0;
         case (state)
            S_IDLE: begin
               if (pick_vld_c) begin
                  state        <= S_FIRE;
                  gidx         <= pick_idx_c;
                  bus.grant    <= pick_oh_c;
                  bus.trig_out <= 1'b1;
                  bus.busy     <= 1'b1;
               end
            end
            S_FIRE: begin
               state <= S_WAIT_ACT;
               timer <= '0;
            end
            S_WAIT_ACT: begin
               if (bus.unit_active) begin
                  state <= S_WAIT_DONE;
                  timer <= '0;
               end else if (timer == TO_LAST) begin
                  state   <= S_ERR;
                  bus.err <= bus.grant;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            S_WAIT_DONE: begin
               // done wins over a timeout landing in the same cycle
               if (bus.unit_done) begin
                  state   <= S_ACK;
                  bus.ack <= bus.grant;
               end else if (timer == TO_LAST) begin
                  state   <= S_ERR;
                  bus.err <= bus.grant;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            S_ACK, S_ERR: begin
               state     <= S_GAP;
               bus.grant <= '0;
               rr_ptr    <= next_ptr_c;
               timer     <= '0;
            end
            S_GAP: begin
               if (timer == GAP_LAST) begin
                  state    <= S_IDLE;
                  bus.busy <= 1'b0;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: begin
               state     <= S_IDLE;
               bus.grant <= '0;
               bus.busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trigger_scheduler.sv
// Purpose: self-checking bench for trigger_scheduler. A behavioural unit
// model answers each trigger after a chosen latency; expected grants come from
// a plain round-robin pick and expected ack/err timing from the latency rules.
module tb_trigger_scheduler;

   localparam int N = 4;
   localparam int T = 15;
   localparam int G = 2;

   logic clk;
   logic reset_n;

   trigger_scheduler_if #(.N_REQ(N)) bus ();

   trigger_scheduler #(.N_REQ(N), .TIMEOUT(T), .GAP_CYCLES(G)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors;
   int miscompares;
   int cyc;
   int model_rr;
   int last_trig;

   logic [N-1:0] obs_grant, obs_ack, obs_err;
   int obs_trig_cnt, obs_resp_off, obs_resp_cnt, obs_busy_off, obs_t_abs;
   bit obs_stable, obs_gap_clean, obs_hung;

   function automatic int rr_pick(input logic [N-1:0] r, input int p);
      for (int i = 0; i < N; i++)
         if (r[(p + i) % N]) return (p + i) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int idx);
      logic [N-1:0] v;
      v = '0;
      if (idx >= 0) v[idx] = 1'b1;
      return v;
   endfunction

   // Unit answers with active at trig+a (a=0: never) for L cycles, then done.
   function automatic bit exp_ok(input int a, input int L, input bit dn);
      return (a >= 1) && (a <= T) && dn && (L >= 1) && (L <= T);
   endfunction

   function automatic int exp_off(input int a, input int L, input bit dn);
      if (a < 1 || a > T) return T + 1;
      if (dn && L <= T) return a + L + 1;
      return a + T + 1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Drives one job through the unit model and records what the DUT did.
   task automatic run_job(input int a, input int L, input bit dn, input bit clr,
                          input bit noise, input logic [N-1:0] drop);
      int t;
      int r;
      bit seen;
      seen = 0; t = 0; r = -1;
      obs_trig_cnt = 0; obs_grant = '0; obs_ack = '0; obs_err = '0;
      obs_resp_off = -1; obs_resp_cnt = 0; obs_busy_off = -1; obs_t_abs = -1;
      obs_stable = 1; obs_gap_clean = 1; obs_hung = 1;
      for (int k = 0; k < 200; k++) begin
         step();
         if (bus.trig_out === 1'b1) begin
            obs_trig_cnt++;
            if (!seen) begin
               seen = 1; t = cyc; obs_t_abs = cyc; obs_grant = bus.grant;
            end
         end
         if (seen && r < 0 && (bus.grant !== obs_grant || bus.busy !== 1'b1)) obs_stable = 0;
         if (r >= 0 && bus.grant !== '0) obs_gap_clean = 0;
         if (bus.ack !== '0 || bus.err !== '0) begin
            obs_resp_cnt++;
            if (r < 0) begin
               r = cyc; obs_resp_off = cyc - t; obs_ack = bus.ack; obs_err = bus.err;
               if (clr) bus.req = bus.req & ~(bus.ack | bus.err);
            end
         end
         if (r >= 0 && bus.busy === 1'b0) begin
            obs_busy_off = cyc - r; obs_hung = 0;
            break;
         end
         bus.unit_active = seen && a > 0 && cyc >= t + a && cyc < t + a + L;
         bus.unit_done   = seen && a > 0 && dn && cyc == t + a + L;
         if (noise && r >= 0) begin
            bus.unit_active = 1'b1; bus.unit_done = 1'b1;
         end
         if (seen && a > 0 && cyc == t + a) bus.req = bus.req & ~drop;
      end
      bus.unit_active = 1'b0;
      bus.unit_done   = 1'b0;
   endtask

   task automatic test_reset();
      bus.req = '0; bus.unit_active = 1'b0; bus.unit_done = 1'b0;
      reset_n = 1'b0;
      #12;
      if ({bus.trig_out, bus.busy} !== 2'b00) begin
         miscompares++; $display("FAIL reset_trig_busy: got %b want 00", {bus.trig_out, bus.busy});
      end
      vectors++;
      if ({bus.grant, bus.ack, bus.err} !== '0) begin
         miscompares++; $display("FAIL reset_grant_ack_err: got %b want 0", {bus.grant, bus.ack, bus.err});
      end
      vectors++;
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         if ({bus.trig_out, bus.busy, bus.grant} !== '0) begin
            miscompares++; $display("FAIL idle_quiet: got %b want 0", {bus.trig_out, bus.busy, bus.grant});
         end
         vectors++;
      end
      model_rr = 0; last_trig = -1;
   endtask

   task automatic test_single();
      int idx;
      logic [N-1:0] eg;
      bus.req = 4'b0001;
      idx = rr_pick(bus.req, model_rr); eg = onehot(idx);
      run_job(1, 4, 1, 1, 0, '0);
      if (obs_trig_cnt !== 1) begin
         miscompares++; $display("FAIL single_trig_count: got %0d want 1", obs_trig_cnt);
      end
      vectors++;
      if (obs_grant !== 4'b0001 || obs_grant !== eg) begin
         miscompares++; $display("FAIL single_grant: got %b want 0001", obs_grant);
      end
      vectors++;
      if (!obs_stable) begin
         miscompares++; $display("FAIL single_grant_stable: got 0 want 1");
      end
      vectors++;
      if (obs_ack !== eg || obs_err !== '0) begin
         miscompares++; $display("FAIL single_ack: got ack %b err %b want ack %b err 0000", obs_ack, obs_err, eg);
      end
      vectors++;
      if (obs_resp_off !== 6 || obs_resp_cnt !== 1) begin
         miscompares++; $display("FAIL single_ack_timing: got off %0d cnt %0d want off 6 cnt 1", obs_resp_off, obs_resp_cnt);
      end
      vectors++;
      if (obs_busy_off !== G + 1 || obs_hung) begin
         miscompares++; $display("FAIL single_busy_gap: got %0d want %0d", obs_busy_off, G + 1);
      end
      vectors++;
      model_rr = (idx + 1) % N; last_trig = obs_t_abs;
   endtask

   task automatic test_rr(input logic [N-1:0] reqv, input int jobs, input string nm);
      int idx, a, L;
      logic [N-1:0] eg;
      bus.req = reqv;
      for (int j = 0; j < jobs; j++) begin
         idx = rr_pick(bus.req, model_rr); eg = onehot(idx);
         a = $urandom_range(1, 3); L = $urandom_range(1, 4);
         run_job(a, L, 1, 0, 0, '0);
         if (obs_grant !== eg || obs_ack !== eg || obs_err !== '0) begin
            miscompares++;
            $display("FAIL %s_grant_ack job %0d: got grant %b ack %b err %b want %b", nm, j, obs_grant, obs_ack, obs_err, eg);
         end
         vectors++;
         if (obs_resp_off !== a + L + 1 || obs_trig_cnt !== 1 || obs_hung) begin
            miscompares++;
            $display("FAIL %s_timing job %0d: got off %0d trigs %0d want off %0d trigs 1", nm, j, obs_resp_off, obs_trig_cnt, a + L + 1);
         end
         vectors++;
         if (last_trig >= 0) begin
            if (obs_t_abs - last_trig < 4 + G) begin
               miscompares++; $display("FAIL %s_spacing job %0d: got %0d want >= %0d", nm, j, obs_t_abs - last_trig, 4 + G);
            end
            vectors++;
         end
         model_rr = (idx + 1) % N; last_trig = obs_t_abs;
      end
      bus.req = '0;
   endtask

   task automatic test_timeout();
      int idx, a, L;
      bit dn;
      logic [N-1:0] eg;
      for (int c = 0; c < 2; c++) begin
         a = (c == 0) ? 0 : 1; L = 40; dn = 0;
         bus.req = onehot($urandom_range(0, N - 1));
         idx = rr_pick(bus.req, model_rr); eg = onehot(idx);
         run_job(a, L, dn, 1, 0, '0);
         if (obs_err !== eg || obs_ack !== '0) begin
            miscompares++; $display("FAIL timeout_err case %0d: got err %b ack %b want err %b", c, obs_err, obs_ack, eg);
         end
         vectors++;
         if (obs_resp_off !== exp_off(a, L, dn) || obs_resp_cnt !== 1) begin
            miscompares++;
            $display("FAIL timeout_timing case %0d: got off %0d cnt %0d want off %0d cnt 1", c, obs_resp_off, obs_resp_cnt, exp_off(a, L, dn));
         end
         vectors++;
         model_rr = (idx + 1) % N; last_trig = obs_t_abs;
         bus.req = '1;
         idx = rr_pick(bus.req, model_rr); eg = onehot(idx);
         run_job(1, 1, 1, 1, 0, '0);
         if (obs_grant !== eg) begin
            miscompares++; $display("FAIL timeout_rr_advance case %0d: got %b want %b", c, obs_grant, eg);
         end
         vectors++;
         model_rr = (idx + 1) % N; last_trig = obs_t_abs;
         bus.req = '0;
      end
   endtask

   task automatic test_done_priority();
      int ta[4] = '{2, 1, T, T + 1};
      int tl[4] = '{T, T + 1, 1, 1};
      int idx;
      bit ok;
      logic [N-1:0] eg;
      for (int c = 0; c < 4; c++) begin
         bus.req = onehot($urandom_range(0, N - 1));
         idx = rr_pick(bus.req, model_rr); eg = onehot(idx);
         ok = exp_ok(ta[c], tl[c], 1);
         run_job(ta[c], tl[c], 1, 1, 0, '0);
         if (obs_ack !== (ok ? eg : '0) || obs_err !== (ok ? '0 : eg)) begin
            miscompares++;
            $display("FAIL boundary_kind case %0d: got ack %b err %b want ok=%0d grant %b", c, obs_ack, obs_err, ok, eg);
         end
         vectors++;
         if (obs_resp_off !== exp_off(ta[c], tl[c], 1)) begin
            miscompares++; $display("FAIL boundary_timing case %0d: got %0d want %0d", c, obs_resp_off, exp_off(ta[c], tl[c], 1));
         end
         vectors++;
         model_rr = (idx + 1) % N; last_trig = obs_t_abs;
      end
      bus.req = '0;
   endtask

   task automatic test_drop_and_noise();
      int idx;
      bit quiet;
      logic [N-1:0] eg;
      bus.req = 4'b0100;
      idx = rr_pick(bus.req, model_rr); eg = onehot(idx);
      run_job(1, 3, 1, 0, 1, 4'b0100);
      if (obs_ack !== eg || obs_err !== '0 || obs_resp_off !== 5) begin
         miscompares++; $display("FAIL drop_ack: got ack %b off %0d want ack %b off 5", obs_ack, obs_resp_off, eg);
      end
      vectors++;
      if (obs_resp_cnt !== 1 || obs_busy_off !== G + 1 || !obs_gap_clean) begin
         miscompares++;
         $display("FAIL noise_in_gap: got resp %0d busy_off %0d gap_clean %0d want 1 %0d 1", obs_resp_cnt, obs_busy_off, obs_gap_clean, G + 1);
      end
      vectors++;
      model_rr = (idx + 1) % N; last_trig = obs_t_abs;
      quiet = 1;
      bus.unit_active = 1'b1; bus.unit_done = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         if ({bus.trig_out, bus.busy, bus.ack, bus.err} !== '0) quiet = 0;
      end
      bus.unit_active = 1'b0; bus.unit_done = 1'b0;
      if (!quiet) begin
         miscompares++; $display("FAIL idle_noise_ignored: got activity want none");
      end
      vectors++;
   endtask

   task automatic test_reset_mid();
      int idx;
      bit quiet, found;
      bus.req = 4'b0100;
      idx = rr_pick(bus.req, model_rr);
      run_job(1, 2, 1, 1, 0, '0);
      model_rr = (idx + 1) % N;
      bus.req = 4'b1000;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (bus.trig_out === 1'b1) found = 1;
      end
      bus.unit_active = 1'b1;
      step(); step();
      if (!found || bus.busy !== 1'b1 || bus.grant !== 4'b1000) begin
         miscompares++; $display("FAIL pre_abort_job: got busy %b grant %b want 1 1000", bus.busy, bus.grant);
      end
      vectors++;
      #2 reset_n = 1'b0;
      #1;
      if ({bus.trig_out, bus.busy, bus.grant, bus.ack, bus.err} !== '0) begin
         miscompares++;
         $display("FAIL async_reset_outputs: got %b want 0", {bus.trig_out, bus.busy, bus.grant, bus.ack, bus.err});
      end
      vectors++;
      bus.req = '0; bus.unit_active = 1'b0;
      #2 reset_n = 1'b1;
      quiet = 1;
      for (int i = 0; i < 5; i++) begin
         step();
         if ({bus.busy, bus.ack, bus.err} !== '0) quiet = 0;
      end
      if (!quiet) begin
         miscompares++; $display("FAIL no_resp_after_abort: got activity want none");
      end
      vectors++;
      model_rr = 0; last_trig = -1;
      bus.req = 4'b1010;
      idx = rr_pick(bus.req, model_rr);
      run_job(1, 2, 1, 1, 0, '0);
      if (obs_grant !== 4'b0010 || obs_grant !== onehot(idx)) begin
         miscompares++; $display("FAIL rr_after_reset: got %b want 0010", obs_grant);
      end
      vectors++;
      model_rr = (idx + 1) % N; last_trig = obs_t_abs;
      bus.req = '0;
   endtask

   task automatic test_random();
      int idx, a, L, r;
      bit dn, ok;
      logic [N-1:0] eg;
      for (int j = 0; j < 25; j++) begin
         bus.req = 4'($urandom_range(1, 15));
         idx = rr_pick(bus.req, model_rr); eg = onehot(idx);
         r = $urandom_range(0, 9);
         a = (r == 0) ? 0 : (r < 8) ? $urandom_range(1, 4) : $urandom_range(T - 1, T + 2);
         L = ($urandom_range(0, 4) == 0) ? $urandom_range(T - 1, T + 2) : $urandom_range(1, 4);
         dn = ($urandom_range(0, 7) != 0);
         ok = exp_ok(a, L, dn);
         run_job(a, L, dn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), '0);
         if (obs_grant !== eg || obs_trig_cnt !== 1 || !obs_stable) begin
            miscompares++;
            $display("FAIL rand_grant job %0d: got %b trigs %0d stable %0d want %b 1 1", j, obs_grant, obs_trig_cnt, obs_stable, eg);
         end
         vectors++;
         if (obs_ack !== (ok ? eg : '0) || obs_err !== (ok ? '0 : eg) || obs_resp_cnt !== 1) begin
            miscompares++;
            $display("FAIL rand_resp job %0d: got ack %b err %b cnt %0d want ok=%0d grant %b", j, obs_ack, obs_err, obs_resp_cnt, ok, eg);
         end
         vectors++;
         if (obs_resp_off !== exp_off(a, L, dn) || obs_busy_off !== G + 1 || !obs_gap_clean || obs_hung) begin
            miscompares++;
            $display("FAIL rand_timing job %0d: got off %0d busy_off %0d want off %0d busy_off %0d", j, obs_resp_off, obs_busy_off, exp_off(a, L, dn), G + 1);
         end
         vectors++;
         if (last_trig >= 0) begin
            if (obs_t_abs - last_trig < 4 + G) begin
               miscompares++; $display("FAIL rand_spacing job %0d: got %0d want >= %0d", j, obs_t_abs - last_trig, 4 + G);
            end
            vectors++;
         end
         model_rr = (idx + 1) % N; last_trig = obs_t_abs;
      end
      bus.req = '0;
   endtask

   initial begin
      vectors = 0; miscompares = 0; cyc = 0; model_rr = 0; last_trig = -1;
      test_reset();
      test_single();
      test_rr(4'b1010, 3, "rr_1010");
      test_rr(4'b1111, 5, "rr_1111");
      test_timeout();
      test_done_priority();
      test_drop_and_noise();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish want finish, %0d miscompares so far", miscompares);
      $fatal(1);
   end

endmodule
